// File: rtl/yuv_rgb_pkg.sv
// Shared definitions for the YUV 4:2:2 to RGB stream converter:
// group-position states, fixed-point coefficients and rounding constant.
package yuv_rgb_pkg;

    typedef enum logic [1:0] {
        S_U  = 2'd0,
        S_Y1 = 2'd1,
        S_V  = 2'd2,
        S_Y2 = 2'd3
    } state_e;

    localparam int FRAC = 3;

    // Coefficients are scaled by 2^FRAC
    localparam int C_Y  = 8;
    localparam int C_RV = 13;
    localparam int C_GU = -2;
    localparam int C_GV = -6;
    localparam int C_BU = 16;

    localparam int RND = 1 << (FRAC - 1);

endpackage

// File: rtl/pix_fifo.sv
// Small power-of-two FIFO that buffers converted pixels towards the sink.
// Also reports whether the next-cycle occupancy leaves room for another entry.
module pix_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         ready_d_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign valid_o   = (cnt_q != '0);
    assign dout_o    = valid_o ? mem_q[rd_q] : '0;
    assign ready_d_o = (cnt_d < (AW+1)'(DEPTH));

endmodule

// File: rtl/yuv_rgb_stream.sv
// Converts a U,Y1,V,Y2 beat stream into two RGB pixels per group, with
// in_sof resynchronisation and a buffered, backpressured pixel output.
module yuv_rgb_stream
    import yuv_rgb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sof,
    input  logic [DW-1:0]   yuv_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*DW-1:0] rgb_out,
    output logic            sync_err
);

    localparam int EW = DW + 8;

    state_e          state_q, state_d;
    logic [DW-1:0]   grp_q [4];
    logic [DW-1:0]   grp_d [4];
    logic            sync_err_q, sync_err_d;
    logic            in_ready_q;
    logic            push, pop, fifo_ready_d;
    logic [3*DW-1:0] pix_d;

    // Round half up; the extra MSB keeps the +RND from wrapping
    function automatic logic [DW-1:0] round_sat(input logic signed [EW-1:0] ext);
        logic signed [EW:0] r;
        r = $signed({ext[EW-1], ext}) + (EW+1)'(RND);
        r = r >>> FRAC;
        if (r[EW]) return '0;
        if (|r[EW-1:DW]) return '1;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] chan(input logic [DW-1:0] y, u, v,
                                           input int cu, cv);
        logic signed [EW-1:0] ys, us, vs, e;
        ys = $signed({{8{1'b0}}, y});
        us = $signed({{8{u[DW-1]}}, u});
        vs = $signed({{8{v[DW-1]}}, v});
        e  = ys * EW'(C_Y) + us * EW'(cu) + vs * EW'(cv);
        return round_sat(e);
    endfunction

    function automatic logic [3*DW-1:0] pixel(input logic [DW-1:0] y, u, v);
        return {chan(y, u, v, 0, C_RV), chan(y, u, v, C_GU, C_GV), chan(y, u, v, C_BU, 0)};
    endfunction

    always_comb begin
        state_d    = state_q;
        sync_err_d = sync_err_q;
        push       = 1'b0;
        pix_d      = '0;
        for (int i = 0; i < 4; i++) grp_d[i] = grp_q[i];
        if (in_valid && in_ready_q) begin
            if (in_sof) begin
                // A start-of-line beat is always a U; any partial group is dropped
                grp_d[S_U] = yuv_in;
                state_d    = S_Y1;
                if (state_q != S_U) sync_err_d = 1'b1;
            end else begin
                grp_d[state_q] = yuv_in;
                case (state_q)
                    S_U:  state_d = S_Y1;
                    S_Y1: state_d = S_V;
                    S_V: begin
                        state_d = S_Y2;
                        push    = 1'b1;
                        pix_d   = pixel(grp_q[S_Y1], grp_q[S_U], yuv_in);
                    end
                    S_Y2: begin
                        state_d = S_U;
                        push    = 1'b1;
                        pix_d   = pixel(yuv_in, grp_q[S_U], grp_q[S_V]);
                    end
                    default: state_d = S_U;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_U;
            sync_err_q <= 1'b0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < 4; i++) grp_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sync_err_q <= sync_err_d;
            in_ready_q <= fifo_ready_d;
            for (int i = 0; i < 4; i++) grp_q[i] <= grp_d[i];
        end
    end

    assign pop = out_valid && out_ready;

    pix_fifo #(
        .W     (3*DW),
        .DEPTH (OUT_DEPTH)
    ) u_pix_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .din_i     (pix_d),
        .pop_i     (pop),
        .dout_o    (rgb_out),
        .valid_o   (out_valid),
        .ready_d_o (fifo_ready_d)
    );

    assign in_ready = in_ready_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_yuv_rgb_stream.sv
// Directed bench for yuv_rgb_stream with a scoreboard of expected pixels.
module tb_yuv_rgb_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sof = 1'b0;
    logic [DW-1:0] yuv_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [23:0]   rgb_out;
    logic          sync_err;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb [$];

    yuv_rgb_stream #(.DW(DW), .OUT_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .yuv_in    (yuv_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rgb_out   (rgb_out),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cl(input int x);
        int t;
        t = x + 4;
        if (t < 0) return 8'h00;
        t = t / 8;
        if (t > 255) return 8'hFF;
        return t[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [7:0] y, u, v);
        int yi, ui, vi;
        yi = int'(y);
        ui = int'($signed(u));
        vi = int'($signed(v));
        return {cl(8*yi + 13*vi), cl(8*yi - 2*ui - 6*vi), cl(8*yi + 16*ui)};
    endfunction

    // Called and returns at posedge+1
    task automatic beat(input logic [7:0] d, input logic sof);
        logic acc;
        int n;
        in_valid = 1'b1;
        yuv_in   = d;
        in_sof   = sof;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("beat_accept", 32'(acc), 32'd1);
    endtask

    task automatic grp(input logic [7:0] u, y1, v, y2);
        sb.push_back(model(y1, u, v));
        sb.push_back(model(y2, u, v));
        beat(u, 1'b0);
        beat(y1, 1'b0);
        beat(v, 1'b0);
        beat(y2, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_pix", 32'(out_valid), 32'd0);
            end else begin
                chk("pix_order", 32'(rgb_out), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb_out",   32'(rgb_out),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_sync_err",  32'(sync_err),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_pre_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready_rise", 32'(in_ready), 32'd1);

        // Basic conversion with latency checks
        sb.push_back(24'h646464);
        sb.push_back(24'h323232);
        beat(8'h00, 1'b1);
        beat(8'd100, 1'b0);
        beat(8'h00, 1'b0);
        @(negedge clk);
        chk("lat_p0_valid", 32'(out_valid), 32'd1);
        chk("lat_p0_rgb",   32'(rgb_out),   32'h646464);
        @(posedge clk);
        #1;
        beat(8'd50, 1'b0);
        @(negedge clk);
        chk("lat_p1_valid", 32'(out_valid), 32'd1);
        chk("lat_p1_rgb",   32'(rgb_out),   32'h323232);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("basic_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Rounding and saturation with hand-derived values
        sb.push_back(24'h807CA0);
        sb.push_back(24'h807CA0);
        beat(8'h10, 1'b0); beat(8'd128, 1'b0); beat(8'h00, 1'b0); beat(8'd128, 1'b0);
        sb.push_back(24'h030001);
        sb.push_back(24'h030001);
        beat(8'h00, 1'b0); beat(8'd1, 1'b0); beat(8'h01, 1'b0); beat(8'd1, 1'b0);
        sb.push_back(24'hFFA0FF);
        sb.push_back(24'hCE0000);
        beat(8'h00, 1'b0); beat(8'd255, 1'b0); beat(8'h7F, 1'b0); beat(8'd0, 1'b0);
        sb.push_back(24'h006000);
        sb.push_back(24'h006A0A);
        beat(8'h00, 1'b0); beat(8'd0, 1'b0); beat(8'h80, 1'b0); beat(8'd10, 1'b0);
        drain("drain_directed");

        // Backpressure: buffer fills, input stalls, output holds
        out_ready = 1'b0;
        grp(8'h20, 8'd60, 8'hF0, 8'd90);
        @(negedge clk);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head",      32'(rgb_out),   32'(sb[0]));
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        yuv_in   = 8'hE0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall", 32'(in_ready), 32'd0);
            chk("bp_hold",  32'(rgb_out),  32'(sb[0]));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        grp(8'hE0, 8'd200, 8'h25, 8'd33);
        drain("drain_bp");

        // Resync: in_sof on the second beat of a group
        @(negedge clk);
        chk("sync_err_before", 32'(sync_err), 32'd0);
        @(posedge clk);
        #1;
        sb.push_back(model(8'd70, 8'h30, 8'hE8));
        sb.push_back(model(8'd40, 8'h30, 8'hE8));
        beat(8'h11, 1'b0);
        beat(8'h30, 1'b1);
        beat(8'd70, 1'b0);
        beat(8'hE8, 1'b0);
        beat(8'd40, 1'b0);
        drain("drain_resync");
        @(negedge clk);
        chk("sync_err_set", 32'(sync_err), 32'd1);
        @(posedge clk);
        #1;

        // Mid-group reset with one pixel buffered
        out_ready = 1'b0;
        beat(8'h05, 1'b0);
        beat(8'd90, 1'b0);
        beat(8'h07, 1'b0);
        @(negedge clk);
        chk("pre_rst_buffered", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sync_err",  32'(sync_err),  32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        grp(8'h90, 8'd200, 8'h50, 8'd15);
        drain("drain_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
